// File: rtl/elastic_buffer_pkg.sv
// Shared elastic-buffer constants: COM/SKP symbols and SKP-delete FSM state encoding.
package elastic_buffer_pkg;

    localparam logic [9:0] COM_SYM = 10'b0011111010;
    localparam logic [9:0] SKP_SYM = 10'b0011110100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COM_SEEN = 2'd1,
        SKP_RUN  = 2'd2
    } del_state_t;

endpackage

// File: rtl/write_pointer_control_if.sv
// Symbol-in / pointer-out bundle between the recovered-symbol source and the write pointer logic.
interface write_pointer_control_if #(
    parameter int DATA_WIDTH = 10,
    parameter int PTR_WIDTH  = 5
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic [PTR_WIDTH-1:0]  gray_read_pointer;
    logic [PTR_WIDTH-1:0]  write_address;
    logic [PTR_WIDTH-1:0]  gray_write_pointer;
    logic                  write_enable;
    logic                  full;
    logic                  delete_req;
    logic                  overflow;
    logic [PTR_WIDTH-1:0]  fill_level;

    modport master (
        output data_in, data_valid, gray_read_pointer,
        input  write_address, gray_write_pointer, write_enable, full,
               delete_req, overflow, fill_level
    );

    modport slave (
        input  data_in, data_valid, gray_read_pointer,
        output write_address, gray_write_pointer, write_enable, full,
               delete_req, overflow, fill_level
    );
endinterface

// File: rtl/binToGray.sv
// Binary to reflected-Gray conversion.
// Latency: combinational. Backpressure: none.
module binToGray #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/grayToBin.sv
// Reflected-Gray to binary conversion; bit i is the XOR of all Gray bits at or above i.
// Latency: combinational. Backpressure: none.
module grayToBin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule

// File: rtl/write_pointer_control.sv
// Elastic-buffer write pointer with full/overflow detection; SKP deletion gated by EB_SKP_DELETE_EN.
// Latency: write_enable/gray pointer/fill combinational; full, overflow, delete_req one cycle late.
// Backpressure: none upstream -- symbols arriving while full are lost and flagged by overflow.
module write_pointer_control
    import elastic_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH       = 10,
    parameter int                    BUFFER_DEPTH     = 16,
    parameter logic [DATA_WIDTH-1:0] COM_SYMBOL       = COM_SYM,
    parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL       = SKP_SYM,
    parameter int                    DELETE_THRESHOLD = BUFFER_DEPTH / 2 + 1
) (
    input  logic                    write_clk,
    input  logic                    rst_n,
    write_pointer_control_if.slave  bus
);
    localparam int         A       = $clog2(BUFFER_DEPTH);
    localparam int         PW      = A + 1;
    localparam logic [A:0] DEL_THR = PW'(DELETE_THRESHOLD);

    logic [A:0] wr_addr;
    logic [A:0] gray_wr;
    logic [A:0] rd_bin;
    logic [A:0] fill;
    logic       full_q;
    logic       full_nxt;
    logic       ovf_q;
    logic       drop;
    logic       we;

    binToGray #(.WIDTH(PW)) u_bin_to_gray (.bin(wr_addr), .gray(gray_wr));
    grayToBin #(.WIDTH(PW)) u_gray_to_bin (.gray(bus.gray_read_pointer), .bin(rd_bin));

    assign fill     = wr_addr - rd_bin;
    // Pointers one full lap apart differ in exactly the top two Gray bits.
    assign full_nxt = (gray_wr == {~bus.gray_read_pointer[A:A-1], bus.gray_read_pointer[A-2:0]});
    assign we       = bus.data_valid & ~full_q & ~drop;

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_addr <= wr_addr + {{A{1'b0}}, we};
            full_q  <= full_nxt;
            ovf_q   <= bus.data_valid & full_q & ~drop;
        end
    end

`ifdef EB_SKP_DELETE_EN
    del_state_t state_q;
    del_state_t state_d;
    logic       del_q;

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            del_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            del_q   <= drop;
        end
    end

    // Only the first SKP after a COM may be dropped, so one per ordered set.
    always_comb begin
        state_d = state_q;
        drop    = 1'b0;
        if (bus.data_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.data_in == COM_SYMBOL) state_d = COM_SEEN;
                end
                COM_SEEN: begin
                    if (bus.data_in == SKP_SYMBOL) begin
                        state_d = SKP_RUN;
                        drop    = (fill >= DEL_THR);
                    end else if (bus.data_in != COM_SYMBOL) begin
                        state_d = IDLE;
                    end
                end
                SKP_RUN: begin
                    if (bus.data_in == COM_SYMBOL)      state_d = COM_SEEN;
                    else if (bus.data_in != SKP_SYMBOL) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.delete_req = del_q;
`else
    logic unused_sym;
    assign unused_sym     = ^{bus.data_in, COM_SYMBOL, SKP_SYMBOL, DEL_THR};
    assign drop           = 1'b0;
    assign bus.delete_req = 1'b0;
`endif

    assign bus.write_address      = wr_addr;
    assign bus.gray_write_pointer = gray_wr;
    assign bus.write_enable       = we;
    assign bus.full               = full_q;
    assign bus.overflow           = ovf_q;
    assign bus.fill_level         = fill;
endmodule

// File: tb/tb_write_pointer_control.sv
// Scoreboard bench for write_pointer_control: driver pushes model predictions, monitor compares at negedge.
module tb_write_pointer_control;
    import elastic_buffer_pkg::*;

    localparam int DW    = 10;
    localparam int DEPTH = 16;
    localparam int PW    = 5;
    localparam int THR   = DEPTH / 2 + 1;
`ifdef EB_SKP_DELETE_EN
    localparam bit DEL_EN = 1'b1;
`else
    localparam bit DEL_EN = 1'b0;
`endif
    localparam logic [DW-1:0] DAT = 10'h155;

    logic write_clk = 1'b0;
    logic rst_n     = 1'b0;
    always #5 write_clk = ~write_clk;

    write_pointer_control_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    write_pointer_control #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
        .write_clk (write_clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [4:0] gray;
        logic [4:0] fill;
        logic       full;
        logic       ovf;
        logic       del;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: counts modulo 2*DEPTH and the previous valid symbol's class.
    int m_w, m_rd;
    bit m_full, m_ovf, m_del, m_last_com;

    function automatic logic [4:0] gray5(input int x);
        logic [4:0] v;
        v = 5'(x);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_rd = 0; m_full = 0; m_ovf = 0; m_del = 0; m_last_com = 0;
    endtask

    task automatic step(input bit dv, input logic [DW-1:0] din);
        exp_t e;
        int   fill;
        bit   drop;
        @(posedge write_clk);
        #1;
        bus.data_valid        = dv;
        bus.data_in           = din;
        bus.gray_read_pointer = gray5(m_rd);
        fill = (m_w - m_rd) & 31;
        drop = DEL_EN && dv && (din == SKP_SYM) && m_last_com && (fill >= THR);
        e.we   = dv && !m_full && !drop;
        e.addr = 5'(m_w);
        e.gray = gray5(m_w);
        e.fill = 5'(fill);
        e.full = m_full;
        e.ovf  = m_ovf;
        e.del  = m_del;
        sb.push_back(e);
        m_ovf  = dv && m_full && !drop;
        m_full = (fill == DEPTH);
        m_del  = drop;
        if (e.we) m_w = (m_w + 1) & 31;
        if (dv) m_last_com = (din == COM_SYM);
    endtask

    task automatic reset_dut();
        @(negedge write_clk);
        #2;
        rst_n = 1'b0;
        bus.data_valid = 1'b0;
        bus.gray_read_pointer = '0;
        model_reset();
        @(negedge write_clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Async reset asserted between edges while data_valid is still high.
    task automatic mid_reset();
        @(negedge write_clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_addr", 32'(bus.write_address), 0);
        chk("rst_gray", 32'(bus.gray_write_pointer), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_del", 32'(bus.delete_req), 0);
        @(posedge write_clk);
        #1;
        chk("rst_hold_addr", 32'(bus.write_address), 0);
        model_reset();
        bus.data_valid = 1'b0;
        bus.gray_read_pointer = '0;
        @(negedge write_clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_sym();
        int r;
        r = $urandom_range(0, 4);
        if (r == 0) return COM_SYM;
        if (r <= 2) return SKP_SYM;
        return DW'($urandom);
    endfunction

    task automatic ordered_set();
        step(1, COM_SYM);
        step(1, SKP_SYM);
        step(1, SKP_SYM);
        step(1, SKP_SYM);
        step(0, DAT);
        step(0, DAT);
    endtask

    // Monitor: every cycle with a pending prediction is compared field by field.
    initial begin
        forever begin
            @(negedge write_clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("write_enable", 32'(bus.write_enable), 32'(e.we));
                chk("write_address", 32'(bus.write_address), 32'(e.addr));
                chk("gray_write_pointer", 32'(bus.gray_write_pointer), 32'(e.gray));
                chk("fill_level", 32'(bus.fill_level), 32'(e.fill));
                chk("full", 32'(bus.full), 32'(e.full));
                chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                chk("delete_req", 32'(bus.delete_req), 32'(e.del));
            end
        end
    end

    initial begin
        bus.data_valid        = 1'b0;
        bus.data_in           = '0;
        bus.gray_read_pointer = '0;
        model_reset();
        repeat (2) @(negedge write_clk);
        #2;
        chk("init_addr", 32'(bus.write_address), 0);
        chk("init_full", 32'(bus.full), 0);
        chk("init_ovf", 32'(bus.overflow), 0);
        chk("init_del", 32'(bus.delete_req), 0);
        rst_n = 1'b1;

        // Fill to 16 against a stalled reader, then one more symbol after full settles.
        for (int i = 0; i < DEPTH; i++) step(1, DAT);
        step(0, DAT);
        step(1, DAT);
        step(0, DAT);
        step(0, DAT);

        // Wrap: reader trails by a few entries over 40 writes.
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            step(1, DAT);
            if (((m_w - m_rd) & 31) > 3) m_rd = (m_rd + 1) & 31;
        end
        step(0, DAT);
        mid_reset();

        // Ordered set at fill 10 and at fill 4.
        reset_dut();
        for (int i = 0; i < 10; i++) step(1, DAT);
        ordered_set();
        reset_dut();
        for (int i = 0; i < 4; i++) step(1, DAT);
        ordered_set();

        // COM,SKP arriving while full at fill 16.
        reset_dut();
        for (int i = 0; i < DEPTH; i++) step(1, DAT);
        step(0, DAT);
        step(1, COM_SYM);
        step(1, SKP_SYM);
        step(0, DAT);
        step(0, DAT);

        // Random traffic with a wandering reader.
        reset_dut();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, rand_sym());
            if ($urandom_range(0, 2) != 0 && m_rd != m_w) m_rd = (m_rd + 1) & 31;
            if (i == 400) begin
                mid_reset();
            end
        end
        step(0, DAT);
        step(0, DAT);

        @(negedge write_clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/write_pointer_control.md
WRITE_POINTER_CONTROL -- requirements
Module: write_pointer_control

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, symbol width.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 16, entry count, power of two; A = $clog2(BUFFER_DEPTH).
REQ-003 SHALL have parameter COM_SYMBOL, default 10'b0011111010, comma symbol.
REQ-004 SHALL have parameter SKP_SYMBOL, default 10'b0011110100, skip symbol.
REQ-005 SHALL have parameter DELETE_THRESHOLD, default BUFFER_DEPTH/2+1, fill level at or above which one SKP is dropped.
REQ-006 SHALL have ports: write_clk in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: data_in in DATA_WIDTH, recovered symbol; data_valid in 1, data_in qualifier.
REQ-008 SHALL have port gray_read_pointer in A+1, reader pointer, already synchronized into write_clk.
REQ-009 SHALL have outputs: write_address A+1; gray_write_pointer A+1; write_enable 1; full 1; delete_req 1; overflow 1; fill_level A+1.

Function
REQ-010 gray_write_pointer SHALL be the combinational binary-to-Gray conversion of write_address.
REQ-011 fill_level SHALL be combinational: write_address minus the Gray-to-binary value of gray_read_pointer, modulo 2^(A+1).
REQ-012 write_enable SHALL be combinational: data_valid AND NOT full AND NOT drop, where drop is the SKP-delete decision of the current cycle.
REQ-013 write_address SHALL increment by 1 at each write_clk edge where write_enable=1 and hold otherwise; it wraps from 2^(A+1)-1 to 0.
REQ-014 Memory SHALL be addressed by write_address[A-1:0]; bit A is the wrap flag.
REQ-015 full SHALL be registered: next value = (gray_write_pointer == {~gray_read_pointer[A:A-1], gray_read_pointer[A-2:0]}), giving one cycle of latency.
REQ-016 overflow SHALL be a registered one-cycle pulse when data_valid=1 and full=1 in the previous cycle; that symbol is lost.
REQ-017 Delete FSM states SHALL be IDLE, COM_SEEN, SKP_RUN, and the FSM SHALL advance only when data_valid=1.
REQ-018 IDLE: data_in==COM_SYMBOL -> COM_SEEN; otherwise stay in IDLE.
REQ-019 COM_SEEN: data_in==SKP_SYMBOL -> SKP_RUN, with drop=1 when fill_level>=DELETE_THRESHOLD; a COM symbol stays in COM_SEEN; any other symbol -> IDLE.
REQ-020 SKP_RUN: SKP_SYMBOL stays in SKP_RUN with drop=0; COM -> COM_SEEN; anything else -> IDLE.
REQ-021 At most one SKP SHALL be dropped per ordered set, a COM SHALL never be dropped, and the first SKP after COM is the only candidate.
REQ-022 delete_req SHALL be a registered one-cycle pulse in the cycle after drop=1.
REQ-023 If full and drop coincide, drop SHALL take priority and overflow SHALL NOT assert.

Reset
REQ-024 While rst_n=0: write_address=0, full=0, overflow=0, delete_req=0, FSM=IDLE; gray_write_pointer therefore =0.
REQ-025 Reset assertion mid-stream SHALL take effect immediately, without waiting for write_clk; release SHALL be synchronized externally.

Configuration
REQ-026 Macro EB_SKP_DELETE_EN SHALL gate the delete feature.
REQ-027 With EB_SKP_DELETE_EN defined, REQ-017 to REQ-023 SHALL apply.
REQ-028 Without EB_SKP_DELETE_EN, the FSM SHALL be absent, drop=0, delete_req SHALL be tied 0, and all valid non-full symbols SHALL be written.

Structure
REQ-029 COM/SKP symbol constants and the FSM state encoding SHALL live in shared package elastic_buffer_pkg.
REQ-030 The existing binToGray module SHALL be reused, and one new sub-module grayToBin (parameterized width) SHALL be used for the read-pointer conversion.

Verification
REQ-031 Reset: assert rst_n=0 mid-write -> all outputs 0 on the same edge, with no further increment.
REQ-032 Fill: gray_read_pointer=0 with 16 valid writes -> write_address=5'b10000, gray_write_pointer=5'b11000, full=1 one cycle later; 17th symbol -> write_enable=0, overflow pulse, address unchanged.
REQ-033 Wrap: reader advancing, 40 valid writes -> write_address=8, gray_write_pointer=5'b01100, full never set.
REQ-034 Delete: fill_level=10, stream COM,SKP,SKP,SKP -> first SKP not written, exactly one delete_req pulse, write_address +3.
REQ-035 No delete: fill_level=4, same stream -> delete_req stays 0, write_address +4; with EB_SKP_DELETE_EN undefined at fill 10 -> write_address +4.
REQ-036 Corner: a COM,SKP pair arriving while full=1 at fill_level 16 -> SKP dropped, overflow=0, delete_req=1.
